// File: rtl/alu_addsub_pipe_if.sv
// rtl/alu_addsub_pipe_if.sv - operand/result handshake bundle for alu_addsub_pipe
interface alu_addsub_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cf;
    logic             of;
    logic             zf;
    logic             sf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cf, of, zf, sf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cf, of, zf, sf
    );
endinterface

// File: rtl/alu_addsub_pipe.sv
// rtl/alu_addsub_pipe.sv - pipelined add/sub, one carry-ripple slice per stage; flags under ALU_ADDSUB_FLAGS_EN
module alu_addsub_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_addsub_pipe_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    logic stall;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Operands shrink by one slice per stage: stage k only carries the slices it
    // and later stages still have to add; the result grows by one slice on top.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int IW = WIDTH - k * SW;

        logic                  v_src;
        logic                  c_src;
        logic [IW-1:0]         a_src;
        logic [IW-1:0]         b_src;
        logic [(k+1)*SW-1:0]   r_next;
        logic [SW:0]           add;
        logic                  v_q;
        logic                  c_q;
        logic [(k+1)*SW-1:0]   r_q;
`ifdef ALU_ADDSUB_FLAGS_EN
        logic                  z_src;
        logic                  z_q;
`endif

        assign add = {1'b0, a_src[SW-1:0]} + {1'b0, b_src[SW-1:0]} + {{SW{1'b0}}, c_src};

        if (k == 0) begin : head
            // Stage 0 loads only when not stalled, so in_valid here is exactly the accept
            assign v_src  = bus.in_valid;
            assign c_src  = bus.sub;
            assign a_src  = bus.a;
            assign b_src  = bus.b ^ {WIDTH{bus.sub}};
            assign r_next = add[SW-1:0];
`ifdef ALU_ADDSUB_FLAGS_EN
            assign z_src  = 1'b1;
`endif
        end else begin : link
            assign v_src  = stg[k-1].v_q;
            assign c_src  = stg[k-1].c_q;
            assign a_src  = stg[k-1].fwd.a_q;
            assign b_src  = stg[k-1].fwd.b_q;
            assign r_next = {add[SW-1:0], stg[k-1].r_q};
`ifdef ALU_ADDSUB_FLAGS_EN
            assign z_src  = stg[k-1].z_q;
`endif
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (!stall) begin
                v_q <= v_src;
                c_q <= add[SW];
                r_q <= r_next;
            end
        end

        if (k < STAGES - 1) begin : fwd
            logic [IW-SW-1:0] a_q;
            logic [IW-SW-1:0] b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_src[IW-1:SW];
                    b_q <= b_src[IW-1:SW];
                end
            end
        end

`ifdef ALU_ADDSUB_FLAGS_EN
        always_ff @(posedge clk) begin
            if (reset) begin
                z_q <= 1'b0;
            end else if (!stall) begin
                z_q <= z_src & (add[SW-1:0] == '0);
            end
        end

        if (k == STAGES - 1) begin : tail
            logic m_q;

            // Carry into the MSB recovered from sum = a ^ b ^ carry_in at that bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    m_q <= 1'b0;
                end else if (!stall) begin
                    m_q <= add[SW-1] ^ a_src[SW-1] ^ b_src[SW-1];
                end
            end
        end
`endif
    end

    assign bus.out_valid = stg[STAGES-1].v_q;
    assign bus.sum       = stg[STAGES-1].r_q;

`ifdef ALU_ADDSUB_FLAGS_EN
    assign bus.cf = stg[STAGES-1].c_q;
    assign bus.of = stg[STAGES-1].tail.m_q ^ stg[STAGES-1].c_q;
    assign bus.zf = stg[STAGES-1].z_q;
    assign bus.sf = stg[STAGES-1].r_q[WIDTH-1];
`else
    assign bus.cf = 1'b0;
    assign bus.of = 1'b0;
    assign bus.zf = 1'b0;
    assign bus.sf = 1'b0;
`endif
endmodule
